// File: rtl/ssp_pkg.sv
// Shared SSP definitions: default data width and FIFO depth, count-width helper,
// and the push/pop operation encoding used by the TX and RX FIFOs.
package ssp_pkg;

  localparam int SSP_DATA_W       = 8;
  localparam int SSP_TXFIFO_DEPTH = 4;

  // Bit 0 = push, bit 1 = pop, so {pop, push} casts directly onto this type.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // Occupancy has to represent 0..depth inclusive, hence one bit over the pointer width.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ssp_fifo_mem.sv
// DEPTH x DATA_WIDTH register array with one synchronous write port and one
// asynchronous read port; shared by the SSP TX and RX FIFOs. Contents are never reset.
module ssp_fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ssp_txfifo_gen.sv
// Parametrised SSP transmit FIFO: stores every qualified APB write, presents the head
// word show-ahead to the serialiser. Optional low-watermark output via SSP_TXFIFO_WATERMARK_EN.
module ssp_txfifo_gen
  import ssp_pkg::*;
#(
  parameter int DATA_WIDTH = SSP_DATA_W,
  parameter int DEPTH      = SSP_TXFIFO_DEPTH,
  parameter int CNT_WIDTH  = fifo_cnt_width(DEPTH)
`ifdef SSP_TXFIFO_WATERMARK_EN
  ,
  parameter int TX_WMARK   = DEPTH / 2
`endif
) (
  input  logic                  PCLK,
  input  logic                  CLEAR_B,
  input  logic                  PSEL,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  transmit_complete,
  input  logic                  clr_ovf,
  output logic [DATA_WIDTH-1:0] TxData,
  output logic                  tx_ready,
  output logic                  SSPTXINTR,
  output logic [CNT_WIDTH-1:0]  tx_count,
  output logic                  tx_overflow
`ifdef SSP_TXFIFO_WATERMARK_EN
  ,
  output logic                  tx_wmark_intr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  full_q, full_d;
  logic                  ready_q, ready_d;
  logic                  ovf_q, ovf_d;
  logic                  wr_req, push, pop;
  fifo_op_e              op;
  logic [DATA_WIDTH-1:0] head_word;

  // Full/empty are the registered flags, so a push+pop on a full FIFO drops the push.
  assign wr_req = PSEL & PWRITE;
  assign push   = wr_req & ~full_q;
  assign pop    = transmit_complete & ready_q;
  assign op     = fifo_op_e'({pop, push});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    case (op)
      FIFO_PUSH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
      end
      FIFO_POP: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        count_d  = count_q - 1'b1;
      end
      FIFO_BOTH: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: ;
    endcase
    full_d  = (count_d == FULL_CNT);
    ready_d = (count_d != '0);
    // A fresh overflow in the same cycle as clr_ovf keeps the flag set.
    ovf_d   = (wr_req & full_q) | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
    end
  end

  ssp_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_mem (
    .clk     (PCLK),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (PWDATA),
    .rd_addr (rd_ptr_q),
    .rd_data (head_word)
  );

  // Gating by ready keeps TxData at zero while empty, including straight out of reset.
  assign TxData      = ready_q ? head_word : '0;
  assign tx_ready    = ready_q;
  assign SSPTXINTR   = full_q;
  assign tx_count    = count_q;
  assign tx_overflow = ovf_q;

`ifdef SSP_TXFIFO_WATERMARK_EN
  localparam logic [CNT_WIDTH-1:0] WMARK_CNT = CNT_WIDTH'(TX_WMARK);

  logic wmark_q, wmark_d;

  always_comb begin
    wmark_d = (count_d <= WMARK_CNT);
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wmark_q <= 1'b1;
    end else begin
      wmark_q <= wmark_d;
    end
  end

  assign tx_wmark_intr = wmark_q;
`endif

endmodule

// File: doc/ssp_txfifo_gen.md
Name: ssp_txfifo_gen

Overview:
- Parametrised second-generation SSP transmit FIFO: buffers APB write data (PSEL/PWRITE/PWDATA) and presents it in order to the SSP transmit logic via a ready/complete handshake.
- Generalises the fixed 8x4 transmit FIFO:
  - configurable width and depth
  - occupancy count
  - sticky overflow flag
  - no data-value-based write filtering; every qualified write is stored
- Sits between the APB slave decode and the SSP serialiser; drives SSPTXINTR to the interrupt combiner.

Parameters:
- DATA_WIDTH, 8: width of PWDATA, storage words and TxData.
- DEPTH, 4: number of entries. Power of two, minimum 2.
- CNT_WIDTH, $clog2(DEPTH)+1: width of tx_count. Derived; do not override.

Ports:
- PCLK  input  1  clock; all state updates on rising edge.
- CLEAR_B  input  1  asynchronous active-low reset.
- PSEL  input  1  APB select.
- PWRITE  input  1  APB write strobe.
- PWDATA  input  DATA_WIDTH  write data.
- transmit_complete  input  1  serialiser consumed head word (pop request).
- clr_ovf  input  1  synchronous clear of tx_overflow.
- TxData  output  DATA_WIDTH  head-of-FIFO word.
- tx_ready  output  1  FIFO non-empty; TxData valid.
- SSPTXINTR  output  1  FIFO full; APB writes are being dropped.
- tx_count  output  CNT_WIDTH  current occupancy, 0..DEPTH.
- tx_overflow  output  1  sticky: a write was attempted while full.

Behaviour:
- Reset: CLEAR_B low asynchronously sets:
  - wr_ptr=0, rd_ptr=0, count=0
  - tx_ready=0, SSPTXINTR=0, tx_overflow=0, TxData=0
  - Storage array contents are not reset.
  - Reset mid-operation discards all queued data. The first write after CLEAR_B rises lands at entry 0.
- push = PSEL & PWRITE & ~full. pop = transmit_complete & ~empty.
  - full and empty are the registered state at the start of the cycle.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push: mem[wr_ptr] <= PWDATA; wr_ptr++ (wrap).
- Pop: rd_ptr++ (wrap).
- Count update:
  - push only: count+1
  - pop only: count-1
  - push and pop together: count unchanged, both pointers advance.
- Simultaneous push+pop when full: push rejected (full evaluated pre-edge), pop proceeds, overflow flag set. Result count=DEPTH-1.
- Simultaneous push+pop when empty: pop ignored, push proceeds. Result count=1.
- Show-ahead output:
  - TxData = mem[rd_ptr]; tx_ready = (count!=0).
  - Latency: a write accepted at edge N makes tx_ready=1 and TxData=written word visible after edge N (one cycle).
  - After a pop at edge M, the next word (or tx_ready=0) is visible after edge M.
- SSPTXINTR = (count==DEPTH), registered with count. It deasserts the cycle after the first pop from full.
- tx_overflow:
  - Set on any cycle with PSEL & PWRITE & full.
  - Cleared by clr_ovf.
  - If set and clear occur in the same cycle, set wins.
- transmit_complete while empty: no effect, no error flag.
- No state machine beyond pointers/count; all outputs are registered or decoded from registered state (no comb path from inputs to outputs).

Optional Feature:
- Macro: SSP_TXFIFO_WATERMARK_EN.
- Defined:
  - Adds parameter TX_WMARK (default DEPTH/2).
  - Adds output tx_wmark_intr, high when count <= TX_WMARK. It is registered, computed from the next count, reset value 1.
- Undefined: port and parameter absent; behaviour otherwise identical.

Decomposition:
- Shared package ssp_pkg holds:
  - the DATA_WIDTH default (SSP_DATA_W=8) and the DEPTH default (SSP_TXFIFO_DEPTH=4)
  - a function computing CNT_WIDTH
  - the push/pop encoding typedef, reused by the future RX FIFO
- One natural sub-module: ssp_fifo_mem, a DEPTH x DATA_WIDTH register array with 1 write port and 1 async read port. It is shared with the RX FIFO.

Test Plan:
- Reset then write 0xA1 (PSEL=PWRITE=1, one cycle) -> next cycle tx_ready=1, TxData=0xA1, tx_count=1, SSPTXINTR=0.
- Write 0x11,0x22,0x33,0x44 then 0x55 -> SSPTXINTR=1 after 4th, tx_count=4, 0x55 dropped, tx_overflow=1; pops yield 0x11..0x44 in order, then tx_ready=0.
- Write the same value 0x7E twice -> tx_count=2, two pops both return 0x7E.
- Fill to 4, same cycle push 0x99 + pop -> tx_count=3, SSPTXINTR=0, tx_overflow=1, 0x99 not in FIFO; at count=2, push+pop -> count stays 2, order preserved.
- Run 10 push/pop pairs through DEPTH=4 -> data order correct across pointer wrap; repeat with DEPTH=8, DATA_WIDTH=16.
- Three words queued, pull CLEAR_B low mid-cycle -> outputs zero immediately (before the next PCLK edge); next write appears alone with tx_count=1. Assert clr_ovf and a full write together -> tx_overflow stays 1.
